// File: rtl/uart_pkg.sv
// Shared types and constants for the UART peripheral.
// Holds the transmit state encoding and the data/baud counter widths.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam int DATA_BITS  = 8;
  localparam int BAUD_CNT_W = 16;

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period timer shared by the UART transmit and receive halves.
// Ports: sysclk, reset (async, active high), clear (hold count at 0),
// bit_done (one-cycle pulse at count CLKS_PER_BIT-1).
module uart_baud_counter
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10417
) (
  input  logic sysclk,
  input  logic reset,
  input  logic clear,
  output logic bit_done
);

  localparam logic [BAUD_CNT_W-1:0] LAST =
    BAUD_CNT_W'(CLKS_PER_BIT - 1);

  logic [BAUD_CNT_W-1:0] cnt;

  assign bit_done = (cnt == LAST) && !clear;

  // Wraps to 0 at each bit boundary so every bit lasts CLKS_PER_BIT.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear || bit_done) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_sender.sv
// UART transmit half: sends one 8N1/8N2 frame, LSB first, per TX_EN edge.
// Ports: sysclk, reset (async, active high), TX_DATA[7:0], TX_EN,
// TX_STATUS (1 = idle/ready), UART_TX (registered serial line, idles high).
module uart_sender
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10417,
  parameter int STOP_BITS    = 1
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic [7:0] TX_DATA,
  input  logic       TX_EN,
  output logic       TX_STATUS,
  output logic       UART_TX
);

  localparam logic [2:0] LAST_DATA = 3'(DATA_BITS - 1);
  localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

  state_t               state;
  logic [DATA_BITS-1:0] shift;
  logic [2:0]           bit_idx;
  logic                 tx_en_d;
  logic                 req;
  logic                 clear;
  logic                 bit_done;

  assign req   = TX_EN & ~tx_en_d;
  assign clear = (state == IDLE);

  uart_baud_counter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .sysclk  (sysclk),
    .reset   (reset),
    .clear   (clear),
    .bit_done(bit_done)
  );

  // Resets to 1 so a TX_EN already high at reset release is not an edge.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      tx_en_d <= 1'b1;
    end else begin
      tx_en_d <= TX_EN;
    end
  end

  // bit_idx counts data bits in DATA and stop bits in STOP.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      shift     <= '0;
      bit_idx   <= '0;
      UART_TX   <= 1'b1;
      TX_STATUS <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            shift     <= TX_DATA;
            bit_idx   <= '0;
            state     <= START;
            UART_TX   <= 1'b0;
            TX_STATUS <= 1'b0;
          end
        end
        START: begin
          if (bit_done) begin
            state   <= DATA;
            bit_idx <= '0;
            UART_TX <= shift[0];
          end
        end
        DATA: begin
          if (bit_done) begin
            shift <= shift >> 1;
            if (bit_idx == LAST_DATA) begin
              state   <= STOP;
              bit_idx <= '0;
              UART_TX <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              UART_TX <= shift[1];
            end
          end
        end
        STOP: begin
          if (bit_done) begin
            if (bit_idx == LAST_STOP) begin
              state     <= IDLE;
              TX_STATUS <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_sender.sv
// Self-checking bench for uart_sender at CLKS_PER_BIT=4.
// dut1 uses one stop bit, dut2 two; frames checked against a bit-level model.
module tb_uart_sender;

  localparam int CPB = 4;

  logic       sysclk = 1'b0;
  logic       reset;
  logic [7:0] d1, d2;
  logic       e1, e2;
  logic       st1, st2, tx1, tx2;

  int vectors = 0;
  int miscompares = 0;

  always #5 sysclk = ~sysclk;

  uart_sender #(.CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut1 (
    .sysclk   (sysclk),
    .reset    (reset),
    .TX_DATA  (d1),
    .TX_EN    (e1),
    .TX_STATUS(st1),
    .UART_TX  (tx1)
  );

  uart_sender #(.CLKS_PER_BIT(CPB), .STOP_BITS(2)) dut2 (
    .sysclk   (sysclk),
    .reset    (reset),
    .TX_DATA  (d2),
    .TX_EN    (e2),
    .TX_STATUS(st2),
    .UART_TX  (tx2)
  );

  task automatic chk(input string tag, input logic obs,
                     input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic set_in(input int sel, input logic en,
                        input logic [7:0] d);
    if (sel == 2) begin
      e2 = en;
      d2 = d;
    end else begin
      e1 = en;
      d1 = d;
    end
  endtask

  function automatic logic get_tx(input int sel);
    return (sel == 2) ? tx2 : tx1;
  endfunction

  function automatic logic get_st(input int sel);
    return (sel == 2) ? st2 : st1;
  endfunction

  // Frame = start(0), 8 data bits LSB first, then stop bits (1).
  function automatic logic model_bit(input logic [7:0] data,
                                     input int k);
    int b;
    b = k / CPB;
    if (b == 0) return 1'b0;
    if (b <= 8) return data[b-1];
    return 1'b1;
  endfunction

  task automatic chk_idle(input int sel, input string tag);
    chk({tag, " tx"}, get_tx(sel), 1'b1);
    chk({tag, " status"}, get_st(sel), 1'b1);
  endtask

  // mode 0: TX_EN held high; 1: random TX_EN/TX_DATA noise;
  // 2: TX_EN drops then rises with 0xFF at cycle 12.
  task automatic send(input int sel, input logic [7:0] data,
                      input int mode, input int abort_at);
    int         len;
    logic       en;
    logic [7:0] d;
    len = (9 + ((sel == 2) ? 2 : 1)) * CPB;
    @(negedge sysclk);
    set_in(sel, 1'b0, 8'($urandom));
    @(negedge sysclk);
    en = 1'b1;
    d  = data;
    set_in(sel, en, d);
    @(posedge sysclk);
    for (int k = 0; k < len; k++) begin
      @(negedge sysclk);
      chk($sformatf("d%0d %02h tx k=%0d", sel, data, k),
          get_tx(sel), model_bit(data, k));
      chk($sformatf("d%0d %02h busy k=%0d", sel, data, k),
          get_st(sel), 1'b0);
      if (k == abort_at) begin
        #2 reset = 1'b1;
        #1 chk_idle(sel, "async reset");
        @(negedge sysclk);
        chk_idle(sel, "in reset");
        reset = 1'b0;
        repeat (8) begin
          @(negedge sysclk);
          chk_idle(sel, "after abort");
        end
        return;
      end
      if (mode == 1) begin
        if ($urandom_range(3) == 0) en = ~en;
        d = 8'($urandom);
      end else if (mode == 2) begin
        if (k == 3) en = 1'b0;
        if (k == 11) begin
          en = 1'b1;
          d  = 8'hFF;
        end
      end
      set_in(sel, en, d);
    end
    @(negedge sysclk);
    chk_idle(sel, $sformatf("d%0d %02h end", sel, data));
    repeat (6) begin
      @(negedge sysclk);
      chk_idle(sel, "no repeat");
    end
  endtask

  initial begin
    reset = 1'b1;
    e1 = 1'b1;
    e2 = 1'b1;
    d1 = 8'h00;
    d2 = 8'h00;
    #3;
    chk_idle(1, "reset d1");
    chk_idle(2, "reset d2");
    repeat (3) @(negedge sysclk);
    reset = 1'b0;
    repeat (10) begin
      @(negedge sysclk);
      chk_idle(1, "en held d1");
      chk_idle(2, "en held d2");
    end
    send(1, 8'h55, 0, -1);
    send(1, 8'h0F, 2, -1);
    send(1, 8'hC3, 0, 17);
    send(1, 8'hA3, 0, -1);
    send(2, 8'h00, 0, -1);
    for (int i = 0; i < 8; i++) begin
      send(($urandom_range(1) == 0) ? 1 : 2,
           8'($urandom), 1, -1);
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
